// File: rtl/board_reveal_engine.sv
// Minesweeper board engine: mine map storage, neighbour-count computation,
// flip/flag handling with queue-driven flood fill, game state and a VGA read port.
module board_reveal_engine #(
    parameter int COLS = 5,
    parameter int ROWS = 5,
    parameter int IDW  = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           mine_we,
    input  logic [IDW-1:0] mine_id,
    input  logic           mine_val,
    input  logic           start,
    input  logic           flip,
    input  logic           flag,
    input  logic [IDW-1:0] cell_id,
    input  logic [IDW-1:0] rd_id,
    output logic [1:0]     rd_state,
    output logic [3:0]     rd_count,
    output logic           rd_mine,
    output logic           ready,
    output logic           game_over,
    output logic           win,
    output logic [IDW:0]   revealed_cnt
);

    localparam int N = ROWS * COLS;

    typedef logic [IDW-1:0] id_t;
    typedef logic [IDW:0]   cnt_t;

    localparam cnt_t N_CNT = cnt_t'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_READY,
        S_POP,
        S_NBR,
        S_LOST,
        S_WON
    } state_t;

    // True when the id addresses a cell on the board.
    function automatic logic valid_id(input id_t id);
        return {1'b0, id} < N_CNT;
    endfunction

    // Circular queue pointer advance.
    function automatic id_t next_ptr(input id_t p);
        return ({1'b0, p} == N_CNT - cnt_t'(1)) ? '0 : p + id_t'(1);
    endfunction

    // Neighbour k (NW,N,NE,W,E,SW,S,SE) of a cell; bit IDW flags in-bounds, no wrap.
    function automatic logic [IDW:0] neighbour(input id_t id, input logic [2:0] k);
        int r, c, nr, nc;
        logic [IDW:0] res;
        r   = int'(id) / COLS;
        c   = int'(id) % COLS;
        nr  = r;
        nc  = c;
        res = '0;
        case (k)
            3'd0: begin nr = r - 1; nc = c - 1; end
            3'd1: begin nr = r - 1; nc = c;     end
            3'd2: begin nr = r - 1; nc = c + 1; end
            3'd3: begin nr = r;     nc = c - 1; end
            3'd4: begin nr = r;     nc = c + 1; end
            3'd5: begin nr = r + 1; nc = c - 1; end
            3'd6: begin nr = r + 1; nc = c;     end
            3'd7: begin nr = r + 1; nc = c + 1; end
        endcase
        if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
            res = {1'b1, id_t'(nr * COLS + nc)};
        end
        return res;
    endfunction

    state_t       state_q, state_d;
    logic [N-1:0] mine_q, mine_d;
    logic [N-1:0] revealed_q, revealed_d;
    logic [N-1:0] flagged_q, flagged_d;
    logic [N-1:0] queued_q, queued_d;
    logic [3:0]   count_q [N];
    logic [3:0]   count_d [N];
    id_t          idx_q, idx_d;
    logic [2:0]   k_q, k_d;
    id_t          head_q, head_d;
    id_t          tail_q, tail_d;
    cnt_t         qlen_q, qlen_d;
    cnt_t         mine_cnt_q, mine_cnt_d;
    cnt_t         rcnt_q, rcnt_d;
    logic         flip_prev_q, flag_prev_q;
    id_t          queue_q [N];

    logic         flip_edge, flag_edge;
    logic         push_en;
    id_t          push_id;
    logic         do_start;
    logic [3:0]   nbr_sum;
    logic [IDW:0] sum_nbr;
    logic [IDW:0] fill_nbr;
    logic         fill_ok;
    id_t          fill_id;

    assign flip_edge = flip & ~flip_prev_q;
    assign flag_edge = flag & ~flag_prev_q;

    assign fill_nbr = neighbour(idx_q, k_q);
    assign fill_ok  = fill_nbr[IDW];
    assign fill_id  = fill_nbr[IDW-1:0];

    // Mine count around the cell currently addressed by the COUNT sweep.
    always_comb begin
        nbr_sum = '0;
        sum_nbr = '0;
        for (int k = 0; k < 8; k++) begin
            sum_nbr = neighbour(idx_q, 3'(k));
            if (sum_nbr[IDW] && mine_q[sum_nbr[IDW-1:0]]) begin
                nbr_sum = nbr_sum + 4'd1;
            end
        end
    end

    // Next-state logic for the game FSM and all board/queue registers.
    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
        state_d    = state_q;
        mine_d     = mine_q;
        revealed_d = revealed_q;
        flagged_d  = flagged_q;
        queued_d   = queued_q;
        count_d    = count_q;
        idx_d      = idx_q;
        k_d        = k_q;
        head_d     = head_q;
        tail_d     = tail_q;
        qlen_d     = qlen_q;
        mine_cnt_d = mine_cnt_q;
        rcnt_d     = rcnt_q;
        push_en    = 1'b0;
        push_id    = '0;
        do_start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mine_we && valid_id(mine_id)) begin
                    mine_d[mine_id] = mine_val;
                end
                if (start) begin
                    do_start = 1'b1;
                end
            end

            S_COUNT: begin
                count_d[idx_q] = nbr_sum;
                mine_cnt_d     = mine_cnt_q + cnt_t'(mine_q[idx_q]);
                if ({1'b0, idx_q} == N_CNT - cnt_t'(1)) begin
                    state_d = S_READY;
                end else begin
                    idx_d = idx_q + id_t'(1);
                end
            end

            S_READY: begin
                if (rcnt_q == N_CNT - mine_cnt_q && mine_cnt_q != '0) begin
                    state_d = S_WON;
                end else if (flip_edge) begin
                    // A simultaneous flag edge is deliberately dropped here.
                    if (valid_id(cell_id) && !revealed_q[cell_id] && !flagged_q[cell_id]) begin
                        revealed_d[cell_id] = 1'b1;
                        rcnt_d              = rcnt_q + cnt_t'(1);
                        if (mine_q[cell_id]) begin
                            state_d = S_LOST;
                        end else if (count_q[cell_id] == 4'd0) begin
                            queued_d[cell_id] = 1'b1;
                            push_en           = 1'b1;
                            push_id           = cell_id;
                            state_d           = S_POP;
                        end
                    end
                end else if (flag_edge && valid_id(cell_id) && !revealed_q[cell_id]) begin
                    flagged_d[cell_id] = ~flagged_q[cell_id];
                end
            end

            S_POP: begin
                idx_d   = queue_q[head_q];
                head_d  = next_ptr(head_q);
                qlen_d  = qlen_q - cnt_t'(1);
                k_d     = '0;
                state_d = S_NBR;
            end

            S_NBR: begin
                if (fill_ok && !revealed_q[fill_id] && !flagged_q[fill_id] && !queued_q[fill_id]) begin
                    revealed_d[fill_id] = 1'b1;
                    queued_d[fill_id]   = 1'b1;
                    rcnt_d              = rcnt_q + cnt_t'(1);
                    if (count_q[fill_id] == 4'd0) begin
                        push_en = 1'b1;
                        push_id = fill_id;
                    end
                end
                if (k_q == 3'd7) begin
                    state_d = (qlen_q == '0 && !push_en) ? S_READY : S_POP;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end

            S_LOST, S_WON: begin
                if (start) begin
                    do_start = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (push_en) begin
            tail_d = next_ptr(tail_q);
            qlen_d = qlen_d + cnt_t'(1);
        end

        // New game: keep the mine map, wipe all per-game progress.
        if (do_start) begin
            state_d    = S_COUNT;
            idx_d      = '0;
            mine_cnt_d = '0;
            rcnt_d     = '0;
            revealed_d = '0;
            flagged_d  = '0;
            queued_d   = '0;
            head_d     = '0;
            tail_d     = '0;
            qlen_d     = '0;
        end
    end

    // Game state register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Board, counter and queue-pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mine_q      <= '0;
            revealed_q  <= '0;
            flagged_q   <= '0;
            queued_q    <= '0;
            // NOTE: the count array is cleared on reset because the read port exposes it;
            // the queue storage is not, since its pointers alone define what is valid.
            for (int i = 0; i < N; i++) begin
                count_q[i] <= '0;
            end
            idx_q       <= '0;
            k_q         <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            qlen_q      <= '0;
            mine_cnt_q  <= '0;
            rcnt_q      <= '0;
            flip_prev_q <= 1'b0;
            flag_prev_q <= 1'b0;
        end else begin
            mine_q      <= mine_d;
            revealed_q  <= revealed_d;
            flagged_q   <= flagged_d;
            queued_q    <= queued_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            qlen_q      <= qlen_d;
            mine_cnt_q  <= mine_cnt_d;
            rcnt_q      <= rcnt_d;
            flip_prev_q <= flip;
            flag_prev_q <= flag;
        end
    end

    // Flood-fill queue storage.
    always_ff @(posedge clock) begin
        if (push_en) begin
            queue_q[tail_q] <= push_id;
        end
    end

    // Combinational read port for the renderer.
    always_comb begin
        rd_state = 2'd0;
        rd_count = 4'd0;
        rd_mine  = 1'b0;
        if (valid_id(rd_id)) begin
            if (revealed_q[rd_id]) begin
                rd_state = 2'd1;
            end else if (flagged_q[rd_id]) begin
                rd_state = 2'd2;
            end
            rd_count = count_q[rd_id];
            rd_mine  = mine_q[rd_id];
        end
    end

    assign ready        = (state_q == S_READY);
    assign game_over    = (state_q == S_LOST);
    assign win          = (state_q == S_WON);
    assign revealed_cnt = rcnt_q;

endmodule

// File: tb/tb_board_reveal_engine.sv
// Self-checking bench for board_reveal_engine: directed scenarios plus random
// boards compared against a queue-based flood-fill reference model.
`timescale 1ns/1ps
module tb_board_reveal_engine;

    localparam int COLS = 5;
    localparam int ROWS = 5;
    localparam int IDW  = 5;
    localparam int N    = ROWS * COLS;

    logic           clock    = 1'b0;
    logic           reset    = 1'b1;
    logic           mine_we  = 1'b0;
    logic [IDW-1:0] mine_id  = '0;
    logic           mine_val = 1'b0;
    logic           start    = 1'b0;
    logic           flip     = 1'b0;
    logic           flag     = 1'b0;
    logic [IDW-1:0] cell_id  = '0;
    logic [IDW-1:0] rd_id    = '0;
    logic [1:0]     rd_state;
    logic [3:0]     rd_count;
    logic           rd_mine;
    logic           ready;
    logic           game_over;
    logic           win;
    logic [IDW:0]   revealed_cnt;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    board_reveal_engine #(.COLS(COLS), .ROWS(ROWS), .IDW(IDW)) dut (
        .clock(clock), .reset(reset), .mine_we(mine_we), .mine_id(mine_id),
        .mine_val(mine_val), .start(start), .flip(flip), .flag(flag),
        .cell_id(cell_id), .rd_id(rd_id), .rd_state(rd_state), .rd_count(rd_count),
        .rd_mine(rd_mine), .ready(ready), .game_over(game_over), .win(win),
        .revealed_cnt(revealed_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: cell states 0 hidden, 1 revealed, 2 flagged.
    bit m_mine [N];
    int m_cnt  [N];
    int m_st   [N];
    int m_rc;
    int m_mines;
    bit m_over;
    bit m_win;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic void model_win_check();
        if (!m_over && m_mines > 0 && m_rc == N - m_mines) m_win = 1'b1;
    endfunction

    function automatic void model_start();
        m_mines = 0;
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0;
            m_mines += int'(m_mine[i]);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                            c + dc >= 0 && c + dc < COLS) begin
                            cnt += int'(m_mine[(r + dr) * COLS + c + dc]);
                        end
                    end
                end
                m_cnt[r * COLS + c] = cnt;
            end
        end
        m_rc   = 0;
        m_over = 1'b0;
        m_win  = 1'b0;
        model_win_check();
    endfunction

    function automatic void model_flip(input int id);
        int q[$];
        int cur;
        int r;
        int c;
        if (m_over || m_win || id >= N || m_st[id] != 0) return;
        m_st[id] = 1;
        m_rc++;
        if (m_mine[id]) begin
            m_over = 1'b1;
            return;
        end
        if (m_cnt[id] == 0) q.push_back(id);
        while (q.size() > 0) begin
            cur = q.pop_front();
            r   = cur / COLS;
            c   = cur % COLS;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                        c + dc >= 0 && c + dc < COLS) begin
                        int nid = (r + dr) * COLS + c + dc;
                        if (m_st[nid] == 0) begin
                            m_st[nid] = 1;
                            m_rc++;
                            if (m_cnt[nid] == 0) q.push_back(nid);
                        end
                    end
                end
            end
        end
        model_win_check();
    endfunction

    function automatic void model_flag(input int id);
        if (m_over || m_win || id >= N || m_st[id] == 1) return;
        m_st[id] = (m_st[id] == 2) ? 0 : 2;
    endfunction

    function automatic logic [2*N-1:0] model_states();
        logic [2*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[2*i +: 2] = 2'(m_st[i]);
        return v;
    endfunction

    function automatic logic [4*N-1:0] model_counts();
        logic [4*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(m_cnt[i]);
        return v;
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        flip    = 1'b0;
        flag    = 1'b0;
        start   = 1'b0;
        mine_we = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic load_mines(input logic [N-1:0] map);
        for (int i = 0; i < N; i++) begin
            mine_we   = 1'b1;
            mine_id   = IDW'(i);
            mine_val  = map[i];
            m_mine[i] = map[i];
            step(1);
        end
        mine_we = 1'b0;
    endtask

    task automatic start_game();
        int n;
        n     = 0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        while (!ready && !win && n < 100) begin
            step(1);
            n++;
        end
        check("count_bound", 128'(n < 100), 128'(1));
        model_start();
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (!(ready || game_over || win) && n < 1000) begin
            step(1);
            n++;
        end
        check("settle_bound", 128'(n < 1000), 128'(1));
        step(2);
    endtask

    task automatic pulse(input int id, input bit do_flip, input bit do_flag, input int hold);
        cell_id = IDW'(id);
        flip    = do_flip;
        flag    = do_flag;
        step(hold);
        flip = 1'b0;
        flag = 1'b0;
        settle();
    endtask

    task automatic read_board(output logic [2*N-1:0] st, output logic [4*N-1:0] cn,
                              output logic [N-1:0] mn);
        st = '0;
        cn = '0;
        mn = '0;
        for (int i = 0; i < N; i++) begin
            rd_id = IDW'(i);
            #0.1;
            st[2*i +: 2] = rd_state;
            cn[4*i +: 4] = rd_count;
            mn[i]        = rd_mine;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [2*N-1:0] st;
        logic [4*N-1:0] cn;
        logic [N-1:0]   mn;
        read_board(st, cn, mn);
        check({tag, "_state"}, 128'(st), 128'(model_states()));
        check({tag, "_rcnt"}, 128'(revealed_cnt), 128'(m_rc));
        check({tag, "_over"}, 128'(game_over), 128'(m_over));
        check({tag, "_win"}, 128'(win), 128'(m_win));
    endtask

    logic [2*N-1:0] st;
    logic [4*N-1:0] cn;
    logic [N-1:0]   mn;
    logic [2*N-1:0] exp_st;
    logic [N-1:0]   map;
    int             nm;
    int             rid;
    bit             rflag;

    initial begin
        // Reset state.
        do_reset();
        check("rst_ready", 128'(ready), 128'(0));
        check("rst_over", 128'(game_over), 128'(0));
        check("rst_win", 128'(win), 128'(0));
        check("rst_rcnt", 128'(revealed_cnt), 128'(0));
        read_board(st, cn, mn);
        check("rst_states", 128'(st), 128'(0));

        // Mine at 0: exact count latency and neighbour counts.
        map = '0;
        map[0] = 1'b1;
        load_mines(map);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(24);
        check("cnt_not_ready_24", 128'(ready), 128'(0));
        step(1);
        check("cnt_ready_25", 128'(ready), 128'(1));
        model_start();
        read_board(st, cn, mn);
        check("cnt_1", 128'(cn[4*1 +: 4]), 128'(1));
        check("cnt_5", 128'(cn[4*5 +: 4]), 128'(1));
        check("cnt_6", 128'(cn[4*6 +: 4]), 128'(1));
        check("cnt_24", 128'(cn[4*24 +: 4]), 128'(0));
        check("mine_0", 128'(mn[0]), 128'(1));

        // Held flip on 24 floods everything but the mine.
        pulse(24, 1'b1, 1'b0, 20);
        read_board(st, cn, mn);
        check("fill_rcnt", 128'(revealed_cnt), 128'(24));
        check("fill_win", 128'(win), 128'(1));
        check("fill_mine_hidden", 128'(st[0 +: 2]), 128'(0));

        // Mine at 12: numbered flip, then flood that stops at the ring.
        do_reset();
        map = '0;
        map[12] = 1'b1;
        load_mines(map);
        start_game();
        pulse(7, 1'b1, 1'b0, 1);
        check("ring_rcnt1", 128'(revealed_cnt), 128'(1));
        check("ring_ready", 128'(ready), 128'(1));
        pulse(0, 1'b1, 1'b0, 1);
        read_board(st, cn, mn);
        exp_st = '0;
        for (int i = 0; i < N; i++) if (i != 12) exp_st[2*i +: 2] = 2'd1;
        check("ring_states", 128'(st), 128'(exp_st));
        check("ring_rcnt", 128'(revealed_cnt), 128'(24));
        check("ring_win", 128'(win), 128'(1));

        // Flags, flagged flip, mine loss, ignored flip after loss, restart.
        do_reset();
        load_mines(map);
        start_game();
        pulse(3, 1'b0, 1'b1, 1);
        read_board(st, cn, mn);
        check("flag_set", 128'(st[2*3 +: 2]), 128'(2));
        pulse(3, 1'b1, 1'b0, 1);
        read_board(st, cn, mn);
        check("flip_flagged", 128'(st[2*3 +: 2]), 128'(2));
        check("flip_flagged_rcnt", 128'(revealed_cnt), 128'(0));
        pulse(3, 1'b0, 1'b1, 1);
        read_board(st, cn, mn);
        check("flag_clear", 128'(st[2*3 +: 2]), 128'(0));
        pulse(12, 1'b1, 1'b0, 1);
        read_board(st, cn, mn);
        check("lose_over", 128'(game_over), 128'(1));
        check("lose_state", 128'(st[2*12 +: 2]), 128'(1));
        check("lose_rcnt", 128'(revealed_cnt), 128'(1));
        pulse(0, 1'b1, 1'b0, 1);
        check("lost_ignore", 128'(revealed_cnt), 128'(1));
        start_game();
        read_board(st, cn, mn);
        check("restart_mine_kept", 128'(mn[12]), 128'(1));
        check("restart_rcnt", 128'(revealed_cnt), 128'(0));
        check("restart_states", 128'(st), 128'(0));

        // Out-of-range flip, simultaneous flip+flag, reset mid-fill.
        do_reset();
        map = '0;
        map[18] = 1'b1;
        load_mines(map);
        start_game();
        pulse(30, 1'b1, 1'b0, 1);
        check("oob_rcnt", 128'(revealed_cnt), 128'(0));
        check("oob_ready", 128'(ready), 128'(1));
        pulse(24, 1'b1, 1'b1, 1);
        read_board(st, cn, mn);
        check("flipflag_state", 128'(st[2*24 +: 2]), 128'(1));
        check("flipflag_rcnt", 128'(revealed_cnt), 128'(1));
        cell_id = IDW'(0);
        flip    = 1'b1;
        step(1);
        flip = 1'b0;
        step(4);
        check("midfill_busy", 128'(ready), 128'(0));
        reset = 1'b1;
        step(1);
        read_board(st, cn, mn);
        check("midfill_rst_rcnt", 128'(revealed_cnt), 128'(0));
        check("midfill_rst_ready", 128'(ready), 128'(0));
        check("midfill_rst_states", 128'(st), 128'(0));
        check("midfill_rst_mines", 128'(mn), 128'(0));
        reset = 1'b0;

        // Random boards and random flip/flag sequences against the model.
        for (int t = 0; t < 6; t++) begin
            map = '0;
            nm  = int'($urandom_range(1, 4));
            for (int j = 0; j < nm; j++) map[$urandom_range(0, N - 1)] = 1'b1;
            do_reset();
            load_mines(map);
            start_game();
            read_board(st, cn, mn);
            check("rnd_counts", 128'(cn), 128'(model_counts()));
            check("rnd_mines", 128'(mn), 128'(map));
            for (int s = 0; s < 10; s++) begin
                rid   = int'($urandom_range(0, 31));
                rflag = ($urandom_range(0, 4) == 0);
                pulse(rid, !rflag, rflag, 1);
                if (rflag) model_flag(rid);
                else model_flip(rid);
                compare_all("rnd");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/board_reveal_engine.md
Name: board_reveal_engine

Overview:
Parametrised Minesweeper board engine and the successor to the fixed 5x5 BlockInfo store. It holds a ROWS x COLS mine map and computes the neighbour count of every cell. It handles flip and flag requests, including iterative flood-fill of zero-count regions through an internal queue. It tracks game state (playing/lost/won) and provides a read port for the VGA renderer.

Parameters:
COLS, 5, board width in cells
ROWS, 5, board height in cells
IDW, 5, cell-id width; 2^IDW >= ROWS*COLS required
(N = ROWS*COLS below; cell id = row*COLS + col, row-major)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; clears all state
mine_we  in  1  write mine bit (accepted only in IDLE)
mine_id  in  IDW  cell id for mine_we
mine_val  in  1  mine bit value
start  in  1  begin count computation / new game (IDLE, LOST, WON)
flip  in  1  reveal request, rising-edge detected (level may be held)
flag  in  1  flag-toggle request, rising-edge detected
cell_id  in  IDW  target cell for flip/flag
rd_id  in  IDW  read-port cell id (VGA)
rd_state  out  2  combinational: 0 hidden, 1 revealed, 2 flagged
rd_count  out  4  combinational: neighbour mine count 0..8
rd_mine  out  1  combinational: mine bit
ready  out  1  high only in READY
game_over  out  1  high in LOST
win  out  1  high in WON
revealed_cnt  out  IDW+1  number of revealed cells

Behaviour:
- Reset: state IDLE; all mine, revealed, flag, queued and count bits = 0; ready = game_over = win = 0; revealed_cnt = 0; queue empty; edge registers = 0. Reset in any state, including mid-FILL, takes effect at the next edge.
- rd_id >= N: rd_state/rd_count/rd_mine = 0.
- Edge detect: flip_edge = flip & ~flip_q, likewise for flag. The _q registers update every cycle. An edge that arrives outside READY is dropped, not deferred.
- IDLE: mine_we writes mine[mine_id] (ignored if mine_id >= N). start moves to COUNT.
- COUNT: computes one cell per cycle, id 0..N-1, over 8 in-bounds neighbours with no wrap at row/column edges. Also accumulates mine_cnt. Takes exactly N cycles; ready rises on the cycle after the last count is written. At COUNT entry, revealed, flag and queued bits are cleared.
- READY, flip_edge with cell_id < N, hidden and unflagged (resolved on the next edge):
  - mine: revealed, state LOST.
  - count > 0: revealed, stay READY.
  - count == 0: revealed, marked queued, pushed to queue, state FILL, ready = 0.
- READY, flip on a flagged or revealed cell, or cell_id >= N: no effect.
- READY, flag_edge on a hidden cell toggles its flag; ignored on revealed cells. If flip_edge and flag_edge occur in the same cycle, flip is processed and flag is dropped.
- FILL / POP: dequeue the head cell, then NBR for 8 cycles, k = 0..7 (NW,N,NE,W,E,SW,S,SE). For each neighbour that is in-bounds, hidden, unflagged and not queued: set revealed and queued, revealed_cnt += 1, and push if its count == 0. When the queue is empty after NBR, return to READY.
  - Queue depth is N; queued bits guarantee no overflow.
  - Zero-count cells never have mine neighbours, so FILL never reveals a mine.
- Win check, every cycle in READY: if revealed_cnt == N - mine_cnt and mine_cnt > 0, go to WON. This includes the cycle after a FILL completes.
- LOST/WON: flip and flag are ignored. start restarts COUNT with the mine map kept. Reset returns to IDLE.
- revealed_cnt increments by exactly 1 per newly revealed cell and never double-counts.

Test Plan:
1. Reset held 2 cycles -> ready=0, game_over=0, win=0, revealed_cnt=0, rd_state(any)=0.
2. Mine at id 0, start -> ready=1 exactly 25 cycles after COUNT entry; rd_count(1)=1, rd_count(5)=1, rd_count(6)=1, rd_count(24)=0, rd_mine(0)=1.
3. Mine at 0, flip id 24 held 200 ns -> single flip processed; FILL runs; revealed_cnt=24, then win=1; rd_state(0)=0.
4. Mine at 12 -> flip id 7 gives revealed_cnt=1 with ready held 1. Then flip id 0 floods the ring and reveals 6,7,8,11,13,16,17,18 without expanding them -> revealed_cnt=24, win=1.
5. Mine at 12 -> flag id 3 gives rd_state(3)=2; flip id 3 gives no change; flag id 3 again gives rd_state(3)=0; flip id 12 gives game_over=1, rd_state(12)=1; later flip id 0 gives revealed_cnt unchanged.
6. Flip cell_id=30 -> ignored. Assert reset during FILL -> next cycle state IDLE, revealed_cnt=0, all rd_state=0. Flip and flag edges on id 24 in the same cycle -> cell revealed, not flagged.
